// File: rtl/tribuf_sel_arb.sv
// Registered resolver for NCH tristate-style drivers sharing one W-bit node: bus keeper,
// round-robin arbitration under contention. Define TRIBUF_SEL_CONTENTION_LOG_EN to build err_cnt/sticky.
module tribuf_sel_arb #(
    parameter int            NCH       = 4,
    parameter int            W         = 8,
    parameter logic [W-1:0]  KEEP_INIT = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         oe,
    input  logic [NCH*W-1:0]       data,
    input  logic [W-1:0]           in,
    output logic [W-1:0]           out,
    output logic [W-1:0]           node,
    output logic                   driven,
    output logic [$clog2(NCH)-1:0] owner,
    output logic                   contention,
    output logic [7:0]             err_cnt,
    input  logic                   clr_err,
    output logic                   sticky
);

    localparam int              OW       = $clog2(NCH);
    localparam logic [OW:0]     NCH_W    = (OW+1)'(NCH);
    localparam logic [OW-1:0]   NCH_LO   = OW'(NCH);
    localparam logic [OW-1:0]   PTR_INIT = OW'(NCH - 1);

    logic [W-1:0]  r_node;
    logic [W-1:0]  r_out;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_rr_ptr;
    logic          r_driven;
    logic          r_contention;

    logic [W-1:0]  w_ch_data [NCH];
    logic [OW-1:0] w_rot_idx [NCH];
    logic [NCH-1:0] w_cand;
    logic [OW-1:0] w_sel_idx;
    logic [W-1:0]  w_sel_data;
    logic [W-1:0]  w_node_next;
    logic          w_any;
    logic          w_multi;

    assign w_any   = |oe;
    assign w_multi = |(oe & (oe - {{(NCH-1){1'b0}}, 1'b1}));

    // Candidate gi is the channel (ptr + 1 + gi) mod NCH, so lower gi means higher priority.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [OW:0] w_sum;
            assign w_ch_data[gi] = data[gi*W +: W];
            assign w_sum         = {1'b0, r_rr_ptr} + (OW+1)'(gi + 1);
            assign w_rot_idx[gi] = (w_sum >= NCH_W) ? (w_sum[OW-1:0] - NCH_LO) : w_sum[OW-1:0];
            assign w_cand[gi]    = oe[w_rot_idx[gi]];
        end
    endgenerate

    // With a single driver the rotated search lands on that driver regardless of the pointer.
    always_comb begin
        w_sel_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_cand[k]) begin
                w_sel_idx = w_rot_idx[k];
            end
        end
    end

    assign w_sel_data  = w_ch_data[w_sel_idx];
    assign w_node_next = w_any ? w_sel_data : r_node;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_node       <= KEEP_INIT;
            r_out        <= '0;
            r_owner      <= '0;
            r_rr_ptr     <= PTR_INIT;
            r_driven     <= 1'b0;
            r_contention <= 1'b0;
        end else begin
            r_driven     <= w_any;
            r_contention <= w_multi;
            r_out        <= in & w_node_next;
            r_node       <= w_node_next;
            if (w_any) begin
                r_owner <= w_sel_idx;
            end
            if (w_multi) begin
                r_rr_ptr <= w_sel_idx;
            end
        end
    end

    assign node       = r_node;
    assign out        = r_out;
    assign owner      = r_owner;
    assign driven     = r_driven;
    assign contention = r_contention;

`ifdef TRIBUF_SEL_CONTENTION_LOG_EN
    logic [7:0] r_err_cnt;
    logic       r_sticky;

    // Clear wins over a coincident contention, which then goes uncounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
            r_sticky  <= 1'b0;
        end else if (clr_err) begin
            r_err_cnt <= '0;
            r_sticky  <= 1'b0;
        end else if (w_multi) begin
            r_sticky <= 1'b1;
            if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign err_cnt = r_err_cnt;
    assign sticky  = r_sticky;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_err;
    assign err_cnt      = '0;
    assign sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_tribuf_sel_arb.sv
// Randomized self-checking bench for tribuf_sel_arb against a behavioural model of the
// driver-resolution, round-robin and contention-logging rules.
module tb_tribuf_sel_arb;

    localparam int           NCH  = 4;
    localparam int           W    = 8;
    localparam logic [W-1:0] KEEP = 8'h3C;

    logic             clk;
    logic             rst_n;
    logic [NCH-1:0]   oe;
    logic [NCH*W-1:0] data;
    logic [W-1:0]     in;
    logic [W-1:0]     out;
    logic [W-1:0]     node;
    logic             driven;
    logic [1:0]       owner;
    logic             contention;
    logic [7:0]       err_cnt;
    logic             clr_err;
    logic             sticky;

    int n_checks = 0;
    int n_fails  = 0;

    // Model state
    int         m_node, m_out, m_owner, m_last, m_err;
    logic       m_drv, m_cont, m_sticky;

    tribuf_sel_arb #(.NCH(NCH), .W(W), .KEEP_INIT(KEEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .oe         (oe),
        .data       (data),
        .in         (in),
        .out        (out),
        .node       (node),
        .driven     (driven),
        .owner      (owner),
        .contention (contention),
        .err_cnt    (err_cnt),
        .clr_err    (clr_err),
        .sticky     (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_node = int'(KEEP); m_out = 0; m_owner = 0; m_last = NCH - 1;
        m_err = 0; m_drv = 1'b0; m_cont = 1'b0; m_sticky = 1'b0;
    endtask

    task automatic model_step(input logic [NCH-1:0] s_oe, input logic [NCH*W-1:0] s_data,
                              input logic [W-1:0] s_in, input logic s_clr);
        int n;
        int win;
        int idx;
        logic found;
        logic [W-1:0] v;
        n = 0; win = 0; found = 1'b0;
        for (int i = 0; i < NCH; i++) if (s_oe[i]) n++;
        m_drv  = (n >= 1);
        m_cont = (n >= 2);
        if (n == 1) begin
            for (int i = 0; i < NCH; i++) if (s_oe[i]) win = i;
        end else if (n >= 2) begin
            for (int k = 1; k <= NCH; k++) begin
                idx = (m_last + k) % NCH;
                if (!found && s_oe[idx]) begin
                    win = idx;
                    found = 1'b1;
                end
            end
            m_last = win;
        end
        if (n >= 1) begin
            v = s_data[win*W +: W];
            m_node  = int'(v);
            m_owner = win;
        end
        m_out = int'(s_in) & m_node;
`ifdef TRIBUF_SEL_CONTENTION_LOG_EN
        if (s_clr) begin
            m_err = 0; m_sticky = 1'b0;
        end else if (m_cont) begin
            if (m_err < 255) m_err++;
            m_sticky = 1'b1;
        end
`endif
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".node"}, 32'(node), 32'(m_node));
        chk({ph, ".out"}, 32'(out), 32'(m_out));
        chk({ph, ".owner"}, 32'(owner), 32'(m_owner));
        chk({ph, ".driven"}, 32'(driven), 32'(m_drv));
        chk({ph, ".contention"}, 32'(contention), 32'(m_cont));
        chk({ph, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
        chk({ph, ".sticky"}, 32'(sticky), 32'(m_sticky));
    endtask

    task automatic drive(input string ph, input logic [NCH-1:0] d_oe, input logic [NCH*W-1:0] d_data,
                         input logic [W-1:0] d_in, input logic d_clr);
        oe = d_oe; data = d_data; in = d_in; clr_err = d_clr;
        @(posedge clk);
        #1;
        model_step(d_oe, d_data, d_in, d_clr);
        check_all(ph);
    endtask

    function automatic logic [NCH*W-1:0] rand_data();
        logic [NCH*W-1:0] d;
        for (int i = 0; i < NCH; i++) d[i*W +: W] = W'($urandom);
        return d;
    endfunction

    function automatic logic [NCH-1:0] rand_oe();
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) return '0;
        if (sel == 1) return NCH'(1 << $urandom_range(0, NCH - 1));
        return NCH'($urandom);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        model_reset();
        check_all("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        logic [NCH*W-1:0] d;
        logic [W-1:0] vin;
        oe = '0; data = '0; in = '0; clr_err = 1'b0;
        model_reset();
        do_reset();

        // Single driver then keeper
        d = rand_data();
        d[1*W +: W] = 8'hA5;
        drive("single", 4'b0010, d, 8'hFF, 1'b0);
        chk("single.node_a5", 32'(node), 32'h0000_00A5);
        chk("single.owner1", 32'(owner), 32'd1);
        for (int i = 0; i < 3; i++) begin
            vin = W'($urandom);
            drive("keeper", 4'b0000, rand_data(), vin, 1'b0);
            chk("keeper.out", 32'(out), 32'(vin & 8'hA5));
        end

        // Round-robin from reset
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive("rr", 4'b1111, rand_data(), W'($urandom), 1'b0);
            chk("rr.seq", 32'(owner), 32'(exp_seq[i]));
        end
`ifdef TRIBUF_SEL_CONTENTION_LOG_EN
        chk("rr.err5", 32'(err_cnt), 32'd5);
`else
        chk("rr.err0", 32'(err_cnt), 32'd0);
`endif

        // Saturation, then clear with coincident contention
        for (int i = 0; i < 300; i++) drive("sat", 4'b1111 & NCH'($urandom | 3), rand_data(), W'($urandom), 1'b0);
`ifdef TRIBUF_SEL_CONTENTION_LOG_EN
        chk("sat.err255", 32'(err_cnt), 32'd255);
        chk("sat.sticky", 32'(sticky), 32'd1);
`endif
        drive("clr", 4'b0110, rand_data(), W'($urandom), 1'b1);
        chk("clr.err0", 32'(err_cnt), 32'd0);
        chk("clr.sticky0", 32'(sticky), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            drive("rand", rand_oe(), rand_data(), W'($urandom), ($urandom_range(0, 15) == 0));

        // Reset asserted mid-contention, away from any clock edge
        drive("pre_rst", 4'b1011, rand_data(), W'($urandom), 1'b0);
        drive("pre_rst", 4'b1011, rand_data(), W'($urandom), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #9 rst_n = 1'b1;
        drive("post_rst", 4'b1111, rand_data(), W'($urandom), 1'b0);
        chk("post_rst.owner0", 32'(owner), 32'd0);

        for (int i = 0; i < 200; i++)
            drive("rand2", rand_oe(), rand_data(), W'($urandom), ($urandom_range(0, 31) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/tribuf_sel_arb.md
TRIBUF_SEL_ARB -- requirements
Module: tribuf_sel_arb

Interface
REQ-001 SHALL have parameter NCH, default 4: number of tristate-style drivers merged onto one node (2..16).
REQ-002 SHALL have parameter W, default 8: bus width in bits (1..32).
REQ-003 SHALL have parameter KEEP_INIT, default 0: keeper value loaded at reset, W bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port oe, input, NCH bits: per-channel output enable; bit i high means channel i drives.
REQ-007 SHALL have port data, input, NCH*W bits: channel i data in bits [i*W+W-1 : i*W].
REQ-008 SHALL have port in, input, W bits: qualifier ANDed with the resolved node.
REQ-009 SHALL have port out, output, W bits: registered value of in & node.
REQ-010 SHALL have port node, output, W bits: registered resolved node value, as a selector or keeper rather than Z.
REQ-011 SHALL have port driven, output, 1 bit: node was actively driven by at least one channel in the last sample.
REQ-012 SHALL have port owner, output, clog2(NCH) bits: index of the channel that drove node.
REQ-013 SHALL have port contention, output, 1 bit: one-cycle pulse when two or more oe bits were high in the last sample.
REQ-014 SHALL have port err_cnt, output, 8 bits: saturating count of contention cycles.
REQ-015 SHALL have port clr_err, input, 1 bit: synchronous clear of err_cnt and sticky.
REQ-016 SHALL have port sticky, output, 1 bit: latched high after any contention until clr_err.

Function
REQ-017 SHALL register every output with one-cycle latency: oe, data and in sampled at edge k appear at edge k+1.
REQ-018 SHALL, when exactly one oe bit i is high, load node=data[i], owner=i, driven=1 and contention=0.
REQ-019 SHALL, when no oe bit is high, hold node and owner at their previous values (bus keeper), with driven=0 and contention=0.
REQ-020 SHALL, when two or more oe bits are high, set contention=1 and driven=1, and select by round-robin: the first set bit searching upward from (last owner+1) mod NCH, wrapping around.
REQ-021 SHALL update the round-robin pointer only in contention cycles; single-driver cycles set owner but do not affect fairness beyond that.
REQ-022 SHALL compute out = in & next node in the same cycle, so that out reflects the node value being loaded.
REQ-023 SHALL increment err_cnt by one per contention cycle and saturate at 255 without wrapping.
REQ-024 SHALL give clr_err priority over a simultaneous contention: err_cnt=0 and sticky=0 that cycle, and that contention is not counted.
REQ-025 SHALL produce no X on node or out when oe is all zero.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force node=KEEP_INIT, out=0, owner=0, driven=0, contention=0, err_cnt=0 and sticky=0, with the round-robin pointer at NCH-1 so channel 0 has first priority.
REQ-027 SHALL discard any contention in progress when reset asserts mid-operation; the first sample after rst_n rises is treated as fresh.

Configuration
REQ-028 SHALL, with macro TRIBUF_SEL_CONTENTION_LOG_EN defined, implement err_cnt, sticky and clr_err as specified above.
REQ-029 SHALL, without TRIBUF_SEL_CONTENTION_LOG_EN, tie err_cnt=0 and sticky=0, ignore clr_err, and leave the contention pulse and arbitration unchanged.

Verification
REQ-030 SHALL cover a single driver: NCH=4, W=8, oe=0010, data[1]=8'hA5, in=8'hFF -> next cycle node=A5, out=A5, owner=1, driven=1, contention=0.
REQ-031 SHALL cover the keeper: after REQ-030, oe=0000 for 3 cycles -> node stays A5, owner=1, driven=0, out=in&A5.
REQ-032 SHALL cover round-robin: after reset, oe=1111 held 5 cycles -> owner sequence 0,1,2,3,0, with contention=1 every cycle and err_cnt=5.
REQ-033 SHALL cover saturation and clear: 300 contention cycles -> err_cnt=255 and sticky=1; then clr_err together with contention -> err_cnt=0 and sticky=0.
REQ-034 SHALL cover mid-operation reset: rst_n low during contention -> all outputs take reset values immediately without waiting for clk, and node=KEEP_INIT.
REQ-035 SHALL cover the macro-off build: REQ-032 stimulus -> contention pulses and arbitration identical, err_cnt=0, sticky=0.
